// File: rtl/operand_forward_ctrl.sv
// Operand-fetch control stage: registers decoded operand fields, tracks in-flight
// destinations for forwarding selects, and stalls decode on load-use hazards.
module operand_forward_ctrl #(
  parameter int REG_W  = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [REG_W-1:0]  RA_in,
  input  logic [REG_W-1:0]  RB_in,
  input  logic [REG_W-1:0]  RW_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic              imm_sel_in,
  input  logic              load_in,
  output logic              stall,
  output logic [REG_W-1:0]  RA,
  output logic [REG_W-1:0]  RB,
  output logic [DATA_W-1:0] imm,
  output logic              imm_sel,
  output logic [1:0]        mux_sel_A,
  output logic [1:0]        mux_sel_B,
  output logic [REG_W-1:0]  RW_dm
);

  logic [REG_W-1:0] rw_op, rw_ex, rw_dm, rw_wb;
  logic             load_op;
  logic             accept;
  logic [1:0]       sel_a_nxt, sel_b_nxt;

  // The chain advances one stage before the operands are consumed, so a match
  // on rw_op means the value will sit in EX (01), rw_ex in DM (10), rw_dm in WB (11).
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] op,
    input logic [REG_W-1:0] ex,
    input logic [REG_W-1:0] dm
  );
    if (src == '0)      return 2'b00;
    else if (src == op) return 2'b01;
    else if (src == ex) return 2'b10;
    else if (src == dm) return 2'b11;
    else                return 2'b00;
  endfunction

  always_comb begin
    stall     = 1'b0;
    accept    = 1'b0;
    sel_a_nxt = 2'b00;
    sel_b_nxt = 2'b00;
    if (!rst && valid_in && load_op && (rw_op != '0) &&
        ((RA_in == rw_op) || (!imm_sel_in && (RB_in == rw_op))))
      stall = 1'b1;
    accept    = valid_in && !stall;
    sel_a_nxt = fwd_sel(RA_in, rw_op, rw_ex, rw_dm);
    if (!imm_sel_in)
      sel_b_nxt = fwd_sel(RB_in, rw_op, rw_ex, rw_dm);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rw_op     <= '0;
      rw_ex     <= '0;
      rw_dm     <= '0;
      rw_wb     <= '0;
      load_op   <= 1'b0;
      RA        <= '0;
      RB        <= '0;
      imm       <= '0;
      imm_sel   <= 1'b1;
      mux_sel_A <= 2'b00;
      mux_sel_B <= 2'b00;
    end else begin
      rw_wb <= rw_dm;
      rw_dm <= rw_ex;
      rw_ex <= rw_op;
      if (accept) begin
        rw_op     <= RW_in;
        load_op   <= load_in;
        RA        <= RA_in;
        RB        <= RB_in;
        imm       <= imm_in;
        imm_sel   <= ~imm_sel_in;
        mux_sel_A <= sel_a_nxt;
        mux_sel_B <= sel_b_nxt;
      end else begin
        rw_op     <= '0;
        load_op   <= 1'b0;
        RA        <= '0;
        RB        <= '0;
        imm       <= '0;
        imm_sel   <= 1'b1;
        mux_sel_A <= 2'b00;
        mux_sel_B <= 2'b00;
      end
    end
  end

  assign RW_dm = rw_dm;

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Scoreboard bench for operand_forward_ctrl: the driver queues cycle-tagged
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_operand_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [4:0]  RA_in = '0, RB_in = '0, RW_in = '0;
  logic [15:0] imm_in = '0;
  logic        imm_sel_in = 1'b0;
  logic        load_in = 1'b0;
  logic        stall;
  logic [4:0]  RA, RB, RW_dm;
  logic [15:0] imm;
  logic        imm_sel;
  logic [1:0]  mux_sel_A, mux_sel_B;

  operand_forward_ctrl #(.REG_W(5), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .RA_in(RA_in), .RB_in(RB_in), .RW_in(RW_in), .imm_in(imm_in),
    .imm_sel_in(imm_sel_in), .load_in(load_in),
    .stall(stall), .RA(RA), .RB(RB), .imm(imm), .imm_sel(imm_sel),
    .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B), .RW_dm(RW_dm)
  );

  always #5 clk = ~clk;

  typedef enum int {F_STALL, F_RA, F_RB, F_IMM, F_IMMSEL, F_MSA, F_MSB, F_RWDM} fld_t;
  typedef struct {
    int          tag;
    fld_t        fld;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  bit   done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] actual(fld_t f);
    case (f)
      F_STALL:  return {15'd0, stall};
      F_RA:     return {11'd0, RA};
      F_RB:     return {11'd0, RB};
      F_IMM:    return imm;
      F_IMMSEL: return {15'd0, imm_sel};
      F_MSA:    return {14'd0, mux_sel_A};
      F_MSB:    return {14'd0, mux_sel_B};
      default:  return {11'd0, RW_dm};
    endcase
  endfunction

  // Monitor: compare every queued expectation whose cycle tag has come due.
  always @(negedge clk) begin
    if (!done) begin
      int i;
      i = 0;
      while (i < q.size()) begin
        if (q[i].tag == cyc) begin
          logic [15:0] a;
          a = actual(q[i].fld);
          checks++;
          if (a === q[i].val) passed++;
          else $display("FAIL %s (cycle %0d): got %0h, expected %0h",
                        q[i].name, cyc, a, q[i].val);
          q.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  task automatic expect_at(int off, fld_t f, logic [15:0] v, string name);
    exp_t e;
    e.tag = cyc + off; e.fld = f; e.val = v; e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(logic v, logic [4:0] ra, logic [4:0] rb, logic [4:0] rw,
                       logic [15:0] im, logic isel, logic ld);
    valid_in = v; RA_in = ra; RB_in = rb; RW_in = rw;
    imm_in = im; imm_sel_in = isel; load_in = ld;
  endtask

  task automatic bubbles(int n);
    for (int k = 0; k < n; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    drive(1, 5'd9, 5'd9, 5'd9, 16'h1234, 0, 1);
    expect_at(0, F_STALL,  0, "rst_stall");
    expect_at(0, F_RA,     0, "rst_RA");
    expect_at(0, F_IMM,    0, "rst_imm");
    expect_at(0, F_IMMSEL, 1, "rst_imm_sel");
    expect_at(0, F_MSA,    0, "rst_msA");
    expect_at(0, F_RWDM,   0, "rst_RW_dm");
    tick();
    rst = 1'b0;
    bubbles(1);

    // 1: forward from the immediately older producer
    drive(1, 0, 0, 7, 0, 0, 0); tick();
    drive(1, 7, 3, 0, 0, 0, 0);
    expect_at(1, F_MSA,    1, "t1_msA");
    expect_at(1, F_MSB,    0, "t1_msB");
    expect_at(1, F_IMMSEL, 1, "t1_imm_sel");
    expect_at(1, F_RA,     7, "t1_RA");
    tick();
    bubbles(3);

    // 2: producers three and two stages ahead
    drive(1, 0, 0, 5, 0, 0, 0); tick();
    drive(1, 0, 0, 6, 0, 0, 0); tick();
    drive(1, 0, 0, 7, 0, 0, 0); tick();
    drive(1, 5, 6, 0, 0, 0, 0);
    expect_at(1, F_MSA,  3, "t2_msA");
    expect_at(1, F_MSB,  2, "t2_msB");
    expect_at(1, F_RWDM, 6, "t2_RW_dm");
    expect_at(2, F_RWDM, 7, "t2_RW_dm_next");
    tick();
    bubbles(3);

    // 3: youngest producer wins
    drive(1, 0, 0, 4, 0, 0, 0); tick();
    drive(1, 0, 0, 4, 0, 0, 0); tick();
    drive(1, 4, 0, 0, 0, 0, 0);
    expect_at(1, F_MSA, 1, "t3_msA");
    tick();
    bubbles(3);

    // 4: load-use on A stalls once, then forwards from DM
    drive(1, 0, 0, 9, 0, 0, 1); tick();
    drive(1, 9, 0, 0, 0, 0, 0);
    expect_at(0, F_STALL, 1, "t4_stall");
    expect_at(1, F_RA,    0, "t4_bubble_RA");
    expect_at(1, F_MSA,   0, "t4_bubble_msA");
    expect_at(1, F_MSB,   0, "t4_bubble_msB");
    expect_at(1, F_IMMSEL,1, "t4_bubble_imm_sel");
    tick();
    expect_at(0, F_STALL, 0, "t4_stall_release");
    expect_at(1, F_MSA,   2, "t4_msA");
    expect_at(1, F_RA,    9, "t4_RA");
    tick();
    bubbles(3);

    // 4b: load-use on B; load followed by independent instruction
    drive(1, 0, 0, 10, 0, 0, 1); tick();
    drive(1, 0, 10, 0, 0, 0, 0);
    expect_at(0, F_STALL, 1, "t4b_stall_B");
    tick();
    expect_at(1, F_MSB, 2, "t4b_msB");
    tick();
    drive(1, 0, 0, 11, 0, 0, 1); tick();
    drive(1, 3, 11, 0, 0, 1, 0);
    expect_at(0, F_STALL, 0, "t4b_no_stall_imm");
    expect_at(1, F_MSB,   0, "t4b_msB_imm");
    tick();
    bubbles(3);

    // 5: immediate operand suppresses B forwarding; R0 never forwards
    drive(1, 0, 0, 2, 0, 0, 0); tick();
    drive(1, 0, 2, 0, 16'hFFFF, 1, 0);
    expect_at(1, F_MSB,    0, "t5_msB");
    expect_at(1, F_IMMSEL, 0, "t5_imm_sel");
    expect_at(1, F_IMM,    16'hFFFF, "t5_imm");
    tick();
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    expect_at(1, F_MSA, 0, "t5_msA_r0");
    expect_at(1, F_MSB, 0, "t5_msB_r0");
    tick();
    bubbles(3);

    // 6: reset while stalled clears the chain; held instruction then accepted
    drive(1, 0, 0, 9, 0, 0, 1); tick();
    drive(1, 9, 0, 0, 0, 0, 0);
    expect_at(0, F_STALL, 1, "t6_stall");
    #5 rst = 1'b1;
    #1;
    checks++;
    if (stall === 1'b0) passed++;
    else $display("FAIL t6_stall_forced: got %0b, expected 0", stall);
    tick();
    expect_at(0, F_RA,     0, "t6_rst_RA");
    expect_at(0, F_IMMSEL, 1, "t6_rst_imm_sel");
    expect_at(0, F_MSA,    0, "t6_rst_msA");
    expect_at(0, F_RWDM,   0, "t6_rst_RW_dm");
    rst = 1'b0;
    expect_at(0, F_STALL,  0, "t6_no_stall");
    expect_at(1, F_RA,     9, "t6_held_RA");
    expect_at(1, F_MSA,    0, "t6_held_msA");
    expect_at(1, F_RWDM,   0, "t6_RW_dm_1");
    expect_at(2, F_RWDM,   0, "t6_RW_dm_2");
    expect_at(3, F_RWDM,   0, "t6_RW_dm_3");
    tick();
    bubbles(4);

    done = 1;
    foreach (q[i]) begin
      checks++;
      $display("FAIL %s: expectation for cycle %0d never compared", q[i].name, q[i].tag);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
